// File: rtl/ram_arbiter.sv
// Two-master arbiter for the block-wide data_ram port: instruction cache (IC) versus data cache (DC).
// Round-robin tie-breaking is compiled in with RAM_ARB_RR_EN; otherwise DC has fixed priority.
module ram_arbiter #(
    parameter int ADDR_W  = 30,
    parameter int BLOCK_W = 256
) (
    input  logic               clk,
    input  logic               rst,
    // Handshake: a requester raises en with stable request fields and keeps it up until its
    // ready pulse; the RAM side sees en held for the whole op and answers with a one-cycle ready.
    input  logic               ic_en_i,
    input  logic [ADDR_W-1:0]  ic_addr_i,
    output logic               ic_ready_o,
    output logic [BLOCK_W-1:0] ic_block_o,
    input  logic               dc_en_i,
    input  logic               dc_write_i,
    input  logic [ADDR_W-1:0]  dc_addr_i,
    input  logic [BLOCK_W-1:0] dc_wdata_i,
    output logic               dc_ready_o,
    output logic [BLOCK_W-1:0] dc_block_o,
    output logic               ram_en_o,
    output logic               ram_write_o,
    output logic [ADDR_W-1:0]  ram_addr_o,
    output logic [BLOCK_W-1:0] ram_wdata_o,
    input  logic               ram_ready_i,
    input  logic [BLOCK_W-1:0] ram_block_i,
    output logic               busy_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IC_BUSY = 2'd1,
        DC_BUSY = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t state;
    state_t state_next;
    logic   grant_ic;
    logic   grant_dc;
    logic   done;
    logic   dc_wins_tie;

`ifdef RAM_ARB_RR_EN
    // Set when DC holds the most recent grant; resets to IC so DC takes the first tie.
    logic last_grant_dc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_dc <= 1'b0;
        end else if (grant_dc) begin
            last_grant_dc <= 1'b1;
        end else if (grant_ic) begin
            last_grant_dc <= 1'b0;
        end
    end

    always_comb begin
        dc_wins_tie = !last_grant_dc;
    end
`else
    always_comb begin
        dc_wins_tie = 1'b1;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_ic   = 1'b0;
        grant_dc   = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (dc_en_i && (!ic_en_i || dc_wins_tie)) begin
                    grant_dc   = 1'b1;
                    state_next = DC_BUSY;
                end else if (ic_en_i) begin
                    grant_ic   = 1'b1;
                    state_next = IC_BUSY;
                end
            end
            IC_BUSY, DC_BUSY: begin
                if (ram_ready_i) begin
                    done       = 1'b1;
                    state_next = RELEASE;
                end
            end
            // Bubble cycle lets the finished requester drop en before we arbitrate again.
            RELEASE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // RAM-side request is a latched copy, so requester inputs may move while the op is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_en_o    <= 1'b0;
            ram_write_o <= 1'b0;
            ram_addr_o  <= '0;
            ram_wdata_o <= '0;
        end else if (grant_dc) begin
            ram_en_o    <= 1'b1;
            ram_write_o <= dc_write_i;
            ram_addr_o  <= dc_addr_i;
            ram_wdata_o <= dc_wdata_i;
        end else if (grant_ic) begin
            ram_en_o    <= 1'b1;
            ram_write_o <= 1'b0;
            ram_addr_o  <= ic_addr_i;
            ram_wdata_o <= '0;
        end else if (done) begin
            ram_en_o    <= 1'b0;
            ram_write_o <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ic_ready_o <= 1'b0;
            dc_ready_o <= 1'b0;
            ic_block_o <= '0;
            dc_block_o <= '0;
        end else begin
            ic_ready_o <= 1'b0;
            dc_ready_o <= 1'b0;
            // The returned block is captured for writes too, keeping both paths identical.
            if (done && state == IC_BUSY) begin
                ic_ready_o <= 1'b1;
                ic_block_o <= ram_block_i;
            end
            if (done && state == DC_BUSY) begin
                dc_ready_o <= 1'b1;
                dc_block_o <= ram_block_i;
            end
        end
    end

    assign busy_o = (state != IDLE);

endmodule
